// File: rtl/imem_fetch_port_if.sv
// Fetch-side handshake bundle between the PC logic (master) and the instruction memory (slave).
interface imem_fetch_port_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_fault;
   logic        flush;

   modport master (
      output req_valid, req_addr, rsp_ready, flush,
      input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, flush,
      output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
   );
endinterface

// File: rtl/imem_fetch_port.sv
// Registered instruction memory with a valid/ready fetch port, configurable wait states,
// a program-load write port and fault reporting for misaligned or out-of-range fetches.
module imem_fetch_port #(
   parameter int          DEPTH     = 256,
   parameter int          WAIT      = 0,
   parameter logic [31:0] NOP       = 32'h0000_0013,
   parameter              INIT_FILE = "",
   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   imem_fetch_port_if.slave     bus,
   input  logic                 ld_en_i,
   input  logic [AW-1:0]        ld_addr_i,
   input  logic [31:0]          ld_data_i,
   output logic                 busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT);

   logic [31:0] mem_q [DEPTH];

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_instr_q;
   logic [31:0] rsp_addr_q;
   logic        rsp_fault_q;

   logic        req_ready;
   logic        accept;
   logic        enter_resp;
   logic [31:0] cap_addr_d;
   logic        cap_fault_d;
   logic [31:0] cap_instr_d;

   // Power-on image: a memory full of NOPs.
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] = NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (ld_en_i) begin
         mem_q[ld_addr_i] <= ld_data_i;
      end
   end

   always_comb begin
      req_ready   = rst_n && !bus.flush &&
                    ((state_q == S_IDLE) || ((state_q == S_RESP) && bus.rsp_ready));
      accept      = bus.req_valid && req_ready;
      enter_resp  = (accept && (WAIT == 0)) ||
                    (!bus.flush && (state_q == S_WAIT) && (cnt_q == 4'd1));
      // The capture address is the live request only when RESP follows the accept edge directly.
      cap_addr_d  = (state_q == S_WAIT) ? addr_q : bus.req_addr;
      cap_fault_d = (cap_addr_d[1:0] != 2'b00) || (|cap_addr_d[31:2+AW]);
      cap_instr_d = cap_fault_d ? NOP : mem_q[cap_addr_d[2+:AW]];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_instr_q <= NOP;
         rsp_addr_q  <= '0;
         rsp_fault_q <= 1'b0;
      end else if (bus.flush) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            addr_q <= bus.req_addr;
         end
         if (enter_resp) begin
            state_q     <= S_RESP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_addr_q  <= cap_addr_d;
            rsp_instr_q <= cap_instr_d;
            rsp_fault_q <= cap_fault_d;
         end else if (accept) begin
            state_q     <= S_WAIT;
            cnt_q       <= CNT_LOAD;
            rsp_valid_q <= 1'b0;
         end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - 4'd1;
         end else if ((state_q == S_RESP) && bus.rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_instr = rsp_instr_q;
   assign bus.rsp_addr  = rsp_addr_q;
   assign bus.rsp_fault = rsp_fault_q;
   assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: a WAIT=0 instance exercised by a vector table with a response
// scoreboard, and a WAIT=3 instance exercised by hand-written multi-cycle sequences.
module tb_imem_fetch_port;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        fault;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        fault;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reqValid;
   logic [31:0] reqAddr;
   logic        rspReady;
   logic        flushIn;
   logic        ldEn;
   logic [7:0]  ldAddr;
   logic [31:0] ldData;
   logic        busy0;
   logic        busy3;
   logic        monEn = 1'b0;

   int   nChecks = 0;
   int   nFails  = 0;
   rsp_t sb[$];
   vec_t vecs[10];

   always #5 clk = ~clk;

   imem_fetch_port_if bus0 ();
   imem_fetch_port_if bus3 ();

   assign bus0.req_valid = reqValid;
   assign bus0.req_addr  = reqAddr;
   assign bus0.rsp_ready = rspReady;
   assign bus0.flush     = flushIn;
   assign bus3.req_valid = reqValid;
   assign bus3.req_addr  = reqAddr;
   assign bus3.rsp_ready = rspReady;
   assign bus3.flush     = flushIn;

   imem_fetch_port #(.DEPTH(256), .WAIT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
      .ld_en_i(ldEn), .ld_addr_i(ldAddr), .ld_data_i(ldData), .busy_o(busy0)
   );

   imem_fetch_port #(.DEPTH(256), .WAIT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3.slave),
      .ld_en_i(ldEn), .ld_addr_i(ldAddr), .ld_data_i(ldData), .busy_o(busy3)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic rv, input logic [31:0] a, input logic rr, input logic fl);
      reqValid = rv;
      reqAddr  = a;
      rspReady = rr;
      flushIn  = fl;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic resetPulse();
      nextCycle();
      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      nextCycle();
      rst_n = 1'b1;
   endtask

   // Responses from the WAIT=0 instance are matched in order against what the table expected.
   always @(negedge clk) begin
      if (monEn && bus0.rsp_valid && rspReady && !flushIn) begin
         if (sb.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected response: got addr %h, expected none", bus0.rsp_addr);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            checkOutput("sb rsp_addr",  bus0.rsp_addr,  e.addr);
            checkOutput("sb rsp_instr", bus0.rsp_instr, e.instr);
            checkOutput("sb rsp_fault", 32'(bus0.rsp_fault), 32'(e.fault));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{32'h0000_0000, 32'h0031_00B3, 1'b0};
      vecs[1] = '{32'h0000_0004, 32'h0040_8133, 1'b0};
      vecs[2] = '{32'h0000_0006, NOP,           1'b1};
      vecs[3] = '{32'h0000_0400, NOP,           1'b1};
      vecs[4] = '{32'h0000_0008, 32'h1111_2222, 1'b0};
      vecs[5] = '{32'h0000_03FC, 32'hCAFE_F00D, 1'b0};
      vecs[6] = '{32'h0000_03FE, NOP,           1'b1};
      vecs[7] = '{32'hFFFF_FFFC, NOP,           1'b1};
      vecs[8] = '{32'h0000_000C, NOP,           1'b0};
      vecs[9] = '{32'h0000_0004, 32'h0040_8133, 1'b0};

      rst_n = 1'b0;
      ldEn  = 1'b0;
      ldAddr = '0;
      ldData = '0;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

      // Program is loaded while reset is held.
      nextCycle(); ldEn = 1'b1; ldAddr = 8'd0;   ldData = 32'h0031_00B3;
      nextCycle(); ldEn = 1'b1; ldAddr = 8'd1;   ldData = 32'h0040_8133;
      nextCycle(); ldEn = 1'b1; ldAddr = 8'd2;   ldData = 32'h1111_2222;
      nextCycle(); ldEn = 1'b1; ldAddr = 8'd255; ldData = 32'hCAFE_F00D;
      nextCycle(); ldEn = 1'b0;
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("reset req_ready",  32'(bus0.req_ready), 32'd0);
      checkOutput("reset rsp_valid",  32'(bus0.rsp_valid), 32'd0);
      checkOutput("reset rsp_instr",  bus0.rsp_instr, NOP);
      checkOutput("reset rsp_addr",   bus0.rsp_addr, 32'h0);
      checkOutput("reset rsp_fault",  32'(bus0.rsp_fault), 32'd0);
      checkOutput("reset busy",       32'(busy0), 32'd0);
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

      // Back-to-back table on the WAIT=0 instance.
      monEn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         nextCycle();
         applyStimulus(1'b1, vecs[k].addr, 1'b1, 1'b0);
         sb.push_back(rsp_t'{vecs[k].addr, vecs[k].instr, vecs[k].fault});
         @(negedge clk);
         checkOutput("b2b req_ready", 32'(bus0.req_ready), 32'd1);
         if (k > 0) checkOutput("b2b rsp_valid", 32'(bus0.rsp_valid), 32'd1);
      end
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
      checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
      nextCycle();
      monEn = 1'b0;

      // WAIT=3 latency and ready gating.
      resetPulse();
      applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("w3 accept ready", 32'(bus3.req_ready), 32'd1);
      checkOutput("w3 idle busy",    32'(busy3), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checkOutput("w3 busy",      32'(busy3), 32'd1);
         checkOutput("w3 req_ready", 32'(bus3.req_ready), 32'd0);
         checkOutput("w3 no rsp",    32'(bus3.rsp_valid), 32'd0);
         nextCycle();
      end
      @(negedge clk);
      checkOutput("w3 rsp_valid", 32'(bus3.rsp_valid), 32'd1);
      checkOutput("w3 rsp_instr", bus3.rsp_instr, 32'h0040_8133);
      checkOutput("w3 rsp_addr",  bus3.rsp_addr, 32'h4);
      checkOutput("w3 rsp_fault", 32'(bus3.rsp_fault), 32'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("w3 back to idle valid", 32'(bus3.rsp_valid), 32'd0);
      checkOutput("w3 back to idle busy",  32'(busy3), 32'd0);

      // Backpressure: response held five cycles, then handshake plus new accept on one edge.
      resetPulse();
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      repeat (3) nextCycle();
      for (int h = 0; h < 5; h++) begin
         applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
         @(negedge clk);
         checkOutput("bp rsp_valid", 32'(bus3.rsp_valid), 32'd1);
         checkOutput("bp rsp_instr", bus3.rsp_instr, 32'h0031_00B3);
         checkOutput("bp rsp_addr",  bus3.rsp_addr, 32'h0);
         checkOutput("bp rsp_fault", 32'(bus3.rsp_fault), 32'd0);
         checkOutput("bp req_ready", 32'(bus3.req_ready), 32'd0);
         nextCycle();
      end
      applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("bp release ready", 32'(bus3.req_ready), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("bp new fetch valid", 32'(bus3.rsp_valid), 32'd0);
      checkOutput("bp new fetch busy",  32'(busy3), 32'd1);
      begin
         int lat;
         lat = 0;
         while (!bus3.rsp_valid && lat < 8) begin
            nextCycle();
            @(negedge clk);
            lat++;
         end
         checkOutput("bp second latency", 32'(lat), 32'd3);
         checkOutput("bp second instr",   bus3.rsp_instr, 32'h0040_8133);
         checkOutput("bp second addr",    bus3.rsp_addr, 32'h4);
      end
      nextCycle();

      // Flush while waiting.
      resetPulse();
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("flush wait ready", 32'(bus3.req_ready), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("flush wait no rsp", 32'(bus3.rsp_valid), 32'd0);
         checkOutput("flush wait busy",   32'(busy3), 32'd0);
         nextCycle();
      end

      // Flush in RESP under backpressure, with a competing request.
      resetPulse();
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      repeat (3) nextCycle();
      @(negedge clk);
      checkOutput("flush resp pre valid", 32'(bus3.rsp_valid), 32'd1);
      nextCycle();
      applyStimulus(1'b1, 32'h4, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("flush+req ready", 32'(bus3.req_ready), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("flush resp no rsp", 32'(bus3.rsp_valid), 32'd0);
         checkOutput("flush resp busy",   32'(busy3), 32'd0);
         nextCycle();
      end

      // Reset during WAIT aborts the fetch; memory survives.
      resetPulse();
      applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (3) nextCycle();
      @(negedge clk);
      checkOutput("rst pre rsp_addr", bus3.rsp_addr, 32'h4);
      nextCycle();
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst in wait busy",  32'(busy3), 32'd1);
      checkOutput("rst in wait ready", 32'(bus3.req_ready), 32'd0);
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("rst rsp_valid", 32'(bus3.rsp_valid), 32'd0);
      checkOutput("rst rsp_instr", bus3.rsp_instr, NOP);
      checkOutput("rst rsp_addr",  bus3.rsp_addr, 32'h0);
      checkOutput("rst rsp_fault", 32'(bus3.rsp_fault), 32'd0);
      checkOutput("rst busy",      32'(busy3), 32'd0);
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         @(negedge clk);
         checkOutput("rst no late rsp", 32'(bus3.rsp_valid), 32'd0);
      end
      nextCycle();
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (3) nextCycle();
      @(negedge clk);
      checkOutput("rst refetch valid", 32'(bus3.rsp_valid), 32'd1);
      checkOutput("rst refetch instr", bus3.rsp_instr, 32'h0031_00B3);

      // Load/read collision on word 0 for the WAIT=0 instance: read-first.
      resetPulse();
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
      ldEn = 1'b1; ldAddr = 8'd0; ldData = 32'hDEAD_BEEF;
      @(negedge clk);
      checkOutput("coll req_ready", 32'(bus0.req_ready), 32'd1);
      nextCycle();
      ldEn = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("coll rsp_valid", 32'(bus0.rsp_valid), 32'd1);
      checkOutput("coll old data",  bus0.rsp_instr, 32'h0031_00B3);
      nextCycle();
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("coll new data", bus0.rsp_instr, 32'hDEAD_BEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
